// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multicycle MIPS-style controller.
// Holds the state codes, the recognised opcodes, the ALUOp / ALUSrcB /
// PCSource encodings, and the bundled datapath-control struct that the
// decoder drives and the top module unpacks onto its ports.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEXE = 4'd10,
    S_IMMWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       bne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       done;
  } ctrl_t;

  // States in which the controller waits on a memory handshake.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state-to-controls decoder.
// Optional feature: define MC_CTRL_BNE_EN to drive o_Bne from the latched
// opcode in BRANCH; otherwise bne is tied 0.
// Ports:
//   state      in  current FSM state
//   mem_ready  in  memory handshake (gates IRWrite/PCWrite in FETCH, done in MEMWR)
//   opcode     in  opcode latched in DECODE
//   ctrl       out bundled datapath controls plus the done pulse
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: every field gets a default before the case so no latch is inferred
    // and unlisted controls are 0 in every state (including codes 12-15).
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_BROFF;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.done       = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.done      = mem_ready;
      end
      S_RTEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.done      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.done          = 1'b1;
`ifdef MC_CTRL_BNE_EN
        ctrl.bne           = opcode[0];
`endif
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.done      = 1'b1;
      end
      S_IMMEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (opcode == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      S_IMMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.done      = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle controller top. Holds the state register,
// the opcode latch and the memory-wait watchdog; controls come from
// mc_ctrl_decode. Optional feature macro: MC_CTRL_BNE_EN (bne support).
// Parameter TIMEOUT_CYCLES: wait cycles before abandoning an access; 0 = off.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_opcode         instruction[31:26]
//   i_mem_ready      memory access completes this cycle
//   o_PCWrite .. o_RegDst, o_PCSource, o_ALUOp, o_ALUSrcB  datapath controls
//   o_state          current state code
//   o_done           instruction-complete pulse
//   o_illegal        unknown-opcode pulse (DECODE)
//   o_mem_timeout    watchdog pulse
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_PCWrite,
  output logic       o_PCWriteCond,
  output logic       o_Bne,
  output logic       o_IorD,
  output logic       o_MemRead,
  output logic       o_MemWrite,
  output logic       o_MemtoReg,
  output logic       o_IRWrite,
  output logic       o_ALUSrcA,
  output logic       o_RegWrite,
  output logic       o_RegDst,
  output logic [1:0] o_PCSource,
  output logic [1:0] o_ALUOp,
  output logic [1:0] o_ALUSrcB,
  output logic [3:0] o_state,
  output logic       o_done,
  output logic       o_illegal,
  output logic       o_mem_timeout
);

  state_t     state_q, state_d;
  logic [5:0] opcode_q;
  logic [7:0] wait_q, wait_d;
  logic       waiting;
  logic       timeout;
  logic       illegal;
  ctrl_t      ctrl;

  // A wait cycle is one spent in a memory state without ready; the timeout
  // fires on the wait cycle that brings the count to the limit, so a ready
  // in that same cycle is not a wait and completes normally.
  always_comb begin
    waiting = is_wait_state(state_q) && !i_mem_ready;
    timeout = (TIMEOUT_CYCLES != 0) && waiting &&
              (({24'd0, wait_q} + 32'd1) == TIMEOUT_CYCLES);
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:  if (i_mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_RTYPE:     state_d = S_RTEXE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_ANDI: state_d = S_IMMEXE;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (i_mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (i_mem_ready) state_d = S_FETCH;
      S_RTEXE:  state_d = S_RTWB;
      S_IMMEXE: state_d = S_IMMWB;
      default:  state_d = S_FETCH;  // write-back/branch/jump and codes 12-15
    endcase
    if (timeout) state_d = S_FETCH;
  end

  // The counter saturates so a disabled watchdog cannot wrap; it also clears
  // on a FETCH timeout, where the state itself does not change.
  always_comb begin
    if ((state_d != state_q) || timeout) wait_d = 8'd0;
    else if (waiting && (wait_q != 8'hFF)) wait_d = wait_q + 8'd1;
    else wait_d = wait_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the combinational logic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_FETCH;
      opcode_q <= 6'd0;
      wait_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) opcode_q <= i_opcode;
    end
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (i_mem_ready),
    .opcode    (opcode_q),
    .ctrl      (ctrl)
  );

  // Write strobes and pulses are held off while reset is asserted, even if
  // memory reports ready during reset.
  assign o_PCWrite     = ctrl.pc_write & i_rst_n;
  assign o_IRWrite     = ctrl.ir_write & i_rst_n;
  assign o_PCWriteCond = ctrl.pc_write_cond;
  assign o_Bne         = ctrl.bne;
  assign o_IorD        = ctrl.i_or_d;
  assign o_MemRead     = ctrl.mem_read;
  assign o_MemWrite    = ctrl.mem_write;
  assign o_MemtoReg    = ctrl.mem_to_reg;
  assign o_ALUSrcA     = ctrl.alu_src_a;
  assign o_RegWrite    = ctrl.reg_write;
  assign o_RegDst      = ctrl.reg_dst;
  assign o_PCSource    = ctrl.pc_source;
  assign o_ALUOp       = ctrl.alu_op;
  assign o_ALUSrcB     = ctrl.alu_src_b;
  assign o_done        = ctrl.done;
  assign o_state       = state_q;
  assign o_illegal     = illegal;
  assign o_mem_timeout = timeout & i_rst_n;

endmodule
